// File: rtl/axi_pkg.sv
// Shared AXI3 encodings and FSM state types for the SRAM responder.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] SIZE_4B     = 3'b010;

  // One-hot encodings with IDLE on bit 0
  typedef enum logic [3:0] {
    R_IDLE = 4'b0001,
    R_WAIT = 4'b0010,
    R_READ = 4'b0100,
    R_DATA = 4'b1000
  } rd_state_t;

  typedef enum logic [2:0] {
    W_IDLE = 3'b001,
    W_DATA = 3'b010,
    W_RESP = 3'b100
  } wr_state_t;

  // Only full-word INCR bursts are served; anything else is answered with SLVERR
  function automatic logic is_err(input logic [2:0] size, input logic [1:0] burst);
    return (size != SIZE_4B) || (burst != BURST_INCR);
  endfunction

endpackage

// File: rtl/axi_sram_slave_if.sv
// AXI3 bus bundle between the bridge (master) and the SRAM responder (slave).
interface axi_sram_slave_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;

  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );
endinterface

// File: rtl/sram_1r1w.sv
// Word-wide SRAM model: one registered read port, one byte-enabled write port.
module sram_1r1w #(
  parameter int MEM_AW = 10
) (
  input  logic              clk,
  input  logic              rd_en,
  input  logic [MEM_AW-1:0] rd_addr,
  output logic [31:0]       rd_data,
  input  logic              wr_en,
  input  logic [MEM_AW-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  input  logic [3:0]        wr_be
);

  logic [31:0] mem [0:(1<<MEM_AW)-1];

  // Read and write share one edge so a colliding read sees the old word
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 responder in front of a word SRAM; independent single-outstanding read and write paths.
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int MEM_AW     = 10,
  parameter int RESP_DELAY = 0
) (
  input  logic             aclk,
  input  logic             aresetn,
  axi_sram_slave_if.slave  bus
);

  localparam logic [3:0] DLY_LAST = (RESP_DELAY > 0) ? 4'(RESP_DELAY - 1) : 4'd0;

  rd_state_t         r_state, r_next;
  logic [3:0]        r_id;
  logic [MEM_AW-1:0] r_addr;
  logic [7:0]        r_len, r_cnt;
  logic              r_err;
  logic [3:0]        r_dly;
  logic              r_last, rd_en;
  logic [31:0]       sram_q;

  wr_state_t         w_state, w_next;
  logic [3:0]        w_id;
  logic [MEM_AW-1:0] w_addr;
  logic [7:0]        w_len, w_cnt;
  logic              w_err, w_bad;
  logic              w_last, wr_en;

  logic unused_bits;
  assign unused_bits = ^{bus.wid, bus.arlock, bus.arcache, bus.arprot,
                         bus.awlock, bus.awcache, bus.awprot,
                         bus.araddr[31:MEM_AW+2], bus.araddr[1:0],
                         bus.awaddr[31:MEM_AW+2], bus.awaddr[1:0]};

  assign r_last = (r_cnt == r_len);
  assign w_last = (w_cnt == w_len);

  // Read FSM state register
  always_ff @(posedge aclk) begin
    if (!aresetn) r_state <= R_IDLE;
    else          r_state <= r_next;
  end

  // Read next-state; SRAM read is issued only in R_READ so its output holds through R_DATA
  always_comb begin
    r_next = r_state;
    rd_en  = 1'b0;
    case (r_state)
      R_IDLE: if (bus.arvalid) r_next = (RESP_DELAY > 0) ? R_WAIT : R_READ;
      R_WAIT: if (r_dly == DLY_LAST) r_next = R_READ;
      R_READ: begin
        rd_en  = 1'b1;
        r_next = R_DATA;
      end
      R_DATA: if (bus.rready) r_next = r_last ? R_IDLE : R_READ;
      default: r_next = R_IDLE;
    endcase
  end

  // Read request latch, delay counter and beat/address advance
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_id   <= '0;
      r_addr <= '0;
      r_len  <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
      r_dly  <= '0;
    end else begin
      case (r_state)
        R_IDLE: if (bus.arvalid) begin
          r_id   <= bus.arid;
          r_addr <= bus.araddr[MEM_AW+1:2];
          r_len  <= bus.arlen;
          r_cnt  <= '0;
          r_err  <= is_err(bus.arsize, bus.arburst);
          r_dly  <= '0;
        end
        R_WAIT: r_dly <= r_dly + 4'd1;
        R_DATA: if (bus.rready && !r_last) begin
          r_addr <= r_addr + MEM_AW'(1);
          r_cnt  <= r_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Outputs are forced low while aresetn is asserted so an aborted burst stops at once
  assign bus.arready = aresetn && (r_state == R_IDLE);
  assign bus.rvalid  = aresetn && (r_state == R_DATA);
  assign bus.rlast   = aresetn && (r_state == R_DATA) && r_last;
  assign bus.rdata   = (aresetn && (r_state == R_DATA) && !r_err) ? sram_q : 32'h0;
  assign bus.rresp   = (aresetn && (r_state == R_DATA) && r_err) ? RESP_SLVERR : RESP_OKAY;
  assign bus.rid     = aresetn ? r_id : 4'h0;

  // Write FSM state register
  always_ff @(posedge aclk) begin
    if (!aresetn) w_state <= W_IDLE;
    else          w_state <= w_next;
  end

  // Write next-state; the burst ends on the beat counter, never on wlast
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE: if (bus.awvalid) w_next = W_DATA;
      W_DATA: if (bus.wvalid && w_last) w_next = W_RESP;
      W_RESP: if (bus.bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // Write request latch, beat/address advance and wlast-mismatch tracking
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      w_id   <= '0;
      w_addr <= '0;
      w_len  <= '0;
      w_cnt  <= '0;
      w_err  <= 1'b0;
      w_bad  <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (bus.awvalid) begin
          w_id   <= bus.awid;
          w_addr <= bus.awaddr[MEM_AW+1:2];
          w_len  <= bus.awlen;
          w_cnt  <= '0;
          w_err  <= is_err(bus.awsize, bus.awburst);
          w_bad  <= 1'b0;
        end
        W_DATA: if (bus.wvalid) begin
          w_addr <= w_addr + MEM_AW'(1);
          w_cnt  <= w_cnt + 8'd1;
          if (bus.wlast != w_last) w_bad <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign wr_en       = aresetn && (w_state == W_DATA) && bus.wvalid && !w_err;
  assign bus.awready = aresetn && (w_state == W_IDLE);
  assign bus.wready  = aresetn && (w_state == W_DATA);
  assign bus.bvalid  = aresetn && (w_state == W_RESP);
  assign bus.bresp   = (aresetn && (w_state == W_RESP) && (w_err || w_bad)) ? RESP_SLVERR : RESP_OKAY;
  assign bus.bid     = aresetn ? w_id : 4'h0;

  sram_1r1w #(.MEM_AW(MEM_AW)) u_sram (
    .clk     (aclk),
    .rd_en   (rd_en),
    .rd_addr (r_addr),
    .rd_data (sram_q),
    .wr_en   (wr_en),
    .wr_addr (w_addr),
    .wr_data (bus.wdata),
    .wr_be   (bus.wstrb)
  );

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: bursts, strobes, backpressure, errors, reset abort and response delay.
module tb_axi_sram_slave;
  import axi_pkg::*;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  int checks = 0;
  int failures = 0;
  int lat;
  logic [31:0] wbuf [4];
  logic [31:0] rbuf [4];

  always #5 aclk = ~aclk;

  axi_sram_slave_if bus ();
  axi_sram_slave_if bus_d ();

  axi_sram_slave #(.MEM_AW(10), .RESP_DELAY(0)) dut (
    .aclk(aclk), .aresetn(aresetn), .bus(bus.slave));

  axi_sram_slave #(.MEM_AW(10), .RESP_DELAY(3)) dut_d (
    .aclk(aclk), .aresetn(aresetn), .bus(bus_d.slave));

  task automatic waitCycle();
    @(posedge aclk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Drives every master-side input of both buses to an idle value
  task automatic applyStimulus();
    bus.arid = 0; bus.araddr = 0; bus.arlen = 0; bus.arsize = SIZE_4B; bus.arburst = BURST_INCR;
    bus.arlock = 0; bus.arcache = 0; bus.arprot = 0; bus.arvalid = 0; bus.rready = 0;
    bus.awid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awsize = SIZE_4B; bus.awburst = BURST_INCR;
    bus.awlock = 0; bus.awcache = 0; bus.awprot = 0; bus.awvalid = 0;
    bus.wid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0; bus.wvalid = 0; bus.bready = 0;
    bus_d.arid = 0; bus_d.araddr = 0; bus_d.arlen = 0; bus_d.arsize = SIZE_4B; bus_d.arburst = BURST_INCR;
    bus_d.arlock = 0; bus_d.arcache = 0; bus_d.arprot = 0; bus_d.arvalid = 0; bus_d.rready = 0;
    bus_d.awid = 0; bus_d.awaddr = 0; bus_d.awlen = 0; bus_d.awsize = SIZE_4B; bus_d.awburst = BURST_INCR;
    bus_d.awlock = 0; bus_d.awcache = 0; bus_d.awprot = 0; bus_d.awvalid = 0;
    bus_d.wid = 0; bus_d.wdata = 0; bus_d.wstrb = 0; bus_d.wlast = 0; bus_d.wvalid = 0; bus_d.bready = 0;
  endtask

  // Full write transaction using wbuf; early_last marks a beat that raises wlast too soon
  task automatic writeBurst(input string tag, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input logic [3:0] id,
                            input logic [3:0] strb, input int early_last, input logic [1:0] exp_resp);
    int n;
    bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst; bus.awid = id;
    bus.awvalid = 1;
    n = 0;
    while (!bus.awready && n < 20) begin waitCycle(); n++; end
    checkOutput({tag, " awready"}, 32'(bus.awready), 1);
    waitCycle();
    bus.awvalid = 0;
    for (int i = 0; i <= int'(len); i++) begin
      bus.wdata = wbuf[i]; bus.wstrb = strb; bus.wvalid = 1;
      bus.wlast = (i == int'(len)) || (i == early_last);
      n = 0;
      while (!bus.wready && n < 20) begin waitCycle(); n++; end
      checkOutput({tag, " wready"}, 32'(bus.wready), 1);
      waitCycle();
    end
    bus.wvalid = 0; bus.wlast = 0;
    bus.bready = 1;
    n = 0;
    while (!bus.bvalid && n < 20) begin waitCycle(); n++; end
    checkOutput({tag, " bvalid"}, 32'(bus.bvalid), 1);
    checkOutput({tag, " bid"}, 32'(bus.bid), 32'(id));
    checkOutput({tag, " bresp"}, 32'(bus.bresp), 32'(exp_resp));
    waitCycle();
    bus.bready = 0;
    checkOutput({tag, " bvalid_clear"}, 32'(bus.bvalid), 0);
  endtask

  // Full read transaction compared against rbuf; stall_beat holds rready low for 5 cycles
  task automatic readBurst(input string tag, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic [3:0] id,
                           input logic [1:0] exp_resp, input int stall_beat);
    int n;
    bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst; bus.arid = id;
    bus.arvalid = 1;
    n = 0;
    while (!bus.arready && n < 20) begin waitCycle(); n++; end
    checkOutput({tag, " arready"}, 32'(bus.arready), 1);
    waitCycle();
    bus.arvalid = 0;
    n = 1;
    while (!bus.rvalid && n < 40) begin waitCycle(); n++; end
    checkOutput({tag, " first_rvalid_latency"}, 32'(n), 2);
    for (int i = 0; i <= int'(len); i++) begin
      n = 0;
      while (!bus.rvalid && n < 20) begin waitCycle(); n++; end
      checkOutput($sformatf("%s rvalid[%0d]", tag, i), 32'(bus.rvalid), 1);
      checkOutput($sformatf("%s rdata[%0d]", tag, i), bus.rdata, rbuf[i]);
      checkOutput($sformatf("%s rresp[%0d]", tag, i), 32'(bus.rresp), 32'(exp_resp));
      checkOutput($sformatf("%s rlast[%0d]", tag, i), 32'(bus.rlast), 32'(i == int'(len)));
      checkOutput($sformatf("%s rid[%0d]", tag, i), 32'(bus.rid), 32'(id));
      if (i == stall_beat) begin
        for (int k = 0; k < 5; k++) begin
          waitCycle();
          checkOutput($sformatf("%s stall%0d rvalid", tag, k), 32'(bus.rvalid), 1);
          checkOutput($sformatf("%s stall%0d rdata", tag, k), bus.rdata, rbuf[i]);
          checkOutput($sformatf("%s stall%0d rlast", tag, k), 32'(bus.rlast), 32'(i == int'(len)));
        end
      end
      bus.rready = 1;
      waitCycle();
      bus.rready = 0;
    end
    checkOutput({tag, " rvalid_clear"}, 32'(bus.rvalid), 0);
  endtask

  initial begin
    int n;
    applyStimulus();
    aresetn = 0;
    repeat (3) waitCycle();
    checkOutput("reset arready", 32'(bus.arready), 0);
    checkOutput("reset awready", 32'(bus.awready), 0);
    checkOutput("reset wready", 32'(bus.wready), 0);
    checkOutput("reset rvalid", 32'(bus.rvalid), 0);
    checkOutput("reset bvalid", 32'(bus.bvalid), 0);
    checkOutput("reset rdata", bus.rdata, 0);
    aresetn = 1;
    waitCycle();
    checkOutput("post-reset arready", 32'(bus.arready), 1);
    checkOutput("post-reset awready", 32'(bus.awready), 1);

    $display("[TB] single write/read");
    wbuf = '{32'hDEADBEEF, 32'h0, 32'h0, 32'h0};
    writeBurst("single_wr", 32'h100, 8'd0, SIZE_4B, BURST_INCR, 4'd1, 4'hF, -1, RESP_OKAY);
    rbuf = '{32'hDEADBEEF, 32'h0, 32'h0, 32'h0};
    readBurst("single_rd", 32'h100, 8'd0, SIZE_4B, BURST_INCR, 4'd0, RESP_OKAY, -1);

    $display("[TB] 4-beat INCR with backpressure on beat 2");
    wbuf = '{32'h1, 32'h2, 32'h3, 32'h4};
    writeBurst("incr_wr", 32'h40, 8'd3, SIZE_4B, BURST_INCR, 4'd2, 4'hF, -1, RESP_OKAY);
    rbuf = '{32'h1, 32'h2, 32'h3, 32'h4};
    readBurst("incr_rd", 32'h40, 8'd3, SIZE_4B, BURST_INCR, 4'd3, RESP_OKAY, 1);

    $display("[TB] byte strobes");
    wbuf = '{32'hFFFFFFFF, 32'h0, 32'h0, 32'h0};
    writeBurst("strb_wr1", 32'h200, 8'd0, SIZE_4B, BURST_INCR, 4'd4, 4'hF, -1, RESP_OKAY);
    wbuf = '{32'h11223344, 32'h0, 32'h0, 32'h0};
    writeBurst("strb_wr2", 32'h200, 8'd0, SIZE_4B, BURST_INCR, 4'd5, 4'b0101, -1, RESP_OKAY);
    rbuf = '{32'hFF22FF44, 32'h0, 32'h0, 32'h0};
    readBurst("strb_rd", 32'h200, 8'd0, SIZE_4B, BURST_INCR, 4'd6, RESP_OKAY, -1);

    $display("[TB] address wrap and aliasing");
    wbuf = '{32'hAAAA0001, 32'hBBBB0002, 32'h0, 32'h0};
    writeBurst("wrap_wr", 32'hFFC, 8'd1, SIZE_4B, BURST_INCR, 4'd7, 4'hF, -1, RESP_OKAY);
    rbuf = '{32'hBBBB0002, 32'h0, 32'h0, 32'h0};
    readBurst("alias_rd", 32'h3000, 8'd0, SIZE_4B, BURST_INCR, 4'd8, RESP_OKAY, -1);

    $display("[TB] error responses");
    rbuf = '{32'h0, 32'h0, 32'h0, 32'h0};
    readBurst("err_size_rd", 32'h40, 8'd1, 3'b001, BURST_INCR, 4'd9, RESP_SLVERR, -1);
    wbuf = '{32'h12345678, 32'h0, 32'h0, 32'h0};
    writeBurst("err_burst_wr", 32'h100, 8'd0, SIZE_4B, BURST_FIXED, 4'd10, 4'hF, -1, RESP_SLVERR);
    rbuf = '{32'hDEADBEEF, 32'h0, 32'h0, 32'h0};
    readBurst("err_burst_rd", 32'h100, 8'd0, SIZE_4B, BURST_INCR, 4'd11, RESP_OKAY, -1);
    wbuf = '{32'hA, 32'hB, 32'hC, 32'h0};
    writeBurst("early_wlast_wr", 32'h300, 8'd2, SIZE_4B, BURST_INCR, 4'd12, 4'hF, 0, RESP_SLVERR);
    rbuf = '{32'hA, 32'hB, 32'hC, 32'h0};
    readBurst("early_wlast_rd", 32'h300, 8'd2, SIZE_4B, BURST_INCR, 4'd13, RESP_OKAY, -1);

    $display("[TB] reset during read burst");
    bus.araddr = 32'h40; bus.arlen = 8'd3; bus.arsize = SIZE_4B; bus.arburst = BURST_INCR;
    bus.arid = 4'd14; bus.arvalid = 1;
    n = 0;
    while (!bus.arready && n < 20) begin waitCycle(); n++; end
    waitCycle();
    bus.arvalid = 0;
    n = 0;
    while (!bus.rvalid && n < 20) begin waitCycle(); n++; end
    checkOutput("rstmid beat1 rdata", bus.rdata, 32'h1);
    bus.rready = 1;
    waitCycle();
    bus.rready = 0;
    n = 0;
    while (!bus.rvalid && n < 20) begin waitCycle(); n++; end
    checkOutput("rstmid beat2 rdata", bus.rdata, 32'h2);
    aresetn = 0;
    waitCycle();
    checkOutput("rstmid rvalid", 32'(bus.rvalid), 0);
    checkOutput("rstmid arready", 32'(bus.arready), 0);
    waitCycle();
    aresetn = 1;
    waitCycle();
    checkOutput("rstmid release arready", 32'(bus.arready), 1);
    checkOutput("rstmid release rvalid", 32'(bus.rvalid), 0);
    rbuf = '{32'h1, 32'h0, 32'h0, 32'h0};
    readBurst("rstmid_rd", 32'h40, 8'd0, SIZE_4B, BURST_INCR, 4'd15, RESP_OKAY, -1);

    $display("[TB] RESP_DELAY=3 latency");
    bus_d.araddr = 32'h0; bus_d.arlen = 8'd0; bus_d.arid = 4'd5; bus_d.arvalid = 1;
    n = 0;
    while (!bus_d.arready && n < 20) begin waitCycle(); n++; end
    checkOutput("delay arready", 32'(bus_d.arready), 1);
    waitCycle();
    bus_d.arvalid = 0;
    lat = 1;
    while (!bus_d.rvalid && lat < 40) begin waitCycle(); lat++; end
    checkOutput("delay first_rvalid_latency", 32'(lat), 5);
    checkOutput("delay rlast", 32'(bus_d.rlast), 1);
    checkOutput("delay rid", 32'(bus_d.rid), 5);
    bus_d.rready = 1;
    waitCycle();
    bus_d.rready = 0;
    checkOutput("delay rvalid_clear", 32'(bus_d.rvalid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
